piso_tx: RTL and testbench
==========================

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL provide parameter width_p, default 5, giving the frame data width in bits; legal range is width_p >= 2.
REQ-002 SHALL provide clk_i, input, 1 bit: the single clock; all state updates on posedge.
REQ-003 SHALL provide reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL provide valid_i, input, 1 bit: the parallel word on data_i is offered.
REQ-005 SHALL provide data_i, input, width_p bits: the parallel word to serialize.
REQ-006 SHALL provide ready_o, output, 1 bit: a word is accepted on any posedge where valid_i & ready_o.
REQ-007 SHALL provide serial_o, output, 1 bit: the current serial bit.
REQ-008 SHALL provide serial_valid_o, output, 1 bit: serial_o holds a valid bit; it connects directly to a receiver shift enable.
REQ-009 SHALL provide serial_ready_i, input, 1 bit: a bit transfers on any posedge where serial_valid_o & serial_ready_i.
REQ-010 SHALL provide last_o, output, 1 bit: high while serial_o carries the final bit of a frame.

Function
REQ-011 SHALL implement two states, IDLE and SEND, plus state PARITY only when the Configuration macro is defined.
REQ-012 SHALL, on acceptance, capture data_i into an internal width_p shift register, clear the bit counter, and enter SEND on the next cycle.
REQ-013 SHALL drive bits MSB-first: serial_o = shift register bit width_p-1 in SEND. A receiver shifting into its LSB therefore reconstructs data_i exactly.
REQ-014 SHALL, on each bit transfer in SEND, shift the register left by one with 0 fill and increment the counter.
REQ-015 SHALL hold serial_o, the register and the counter unchanged when serial_valid_o=1 and serial_ready_i=0 (stall); stalls have no limit.
REQ-016 SHALL assert serial_valid_o=1 in SEND/PARITY and 0 in IDLE; serial_o and last_o SHALL be 0 in IDLE.
REQ-017 SHALL assert last_o in SEND when the counter equals width_p-1 (parity disabled), or in PARITY (parity enabled).
REQ-018 SHALL set ready_o = (state==IDLE) | (last_o & serial_ready_i), giving back-to-back frames with zero idle cycles; the path from serial_ready_i to ready_o is combinational.
REQ-019 SHALL handle a last-bit transfer with a simultaneous acceptance by loading the new word and remaining in SEND with the counter cleared.
REQ-020 SHALL handle a last-bit transfer without an acceptance by entering IDLE.
REQ-021 SHALL give a latency of exactly 1 cycle from acceptance to the first bit on serial_o.
REQ-022 SHALL accept no new word while a frame is mid-transfer (counter < final bit).

Reset
REQ-023 SHALL, while reset_i=1 and independent of clk_i, force state=IDLE, counter=0 and shift register=0.
REQ-024 SHALL hold outputs at ready_o=0, serial_valid_o=0, serial_o=0, last_o=0 while reset_i=1.
REQ-025 SHALL, on reset assertion mid-frame, abandon the frame with no further bits emitted.
REQ-026 SHALL assert ready_o=1 in the first cycle after reset_i deasserts.

Configuration
REQ-027 SHALL, when macro PISO_TX_PARITY_EN is defined, append one even-parity bit after the data bits. The parity bit is the XOR of the accepted word and is sent in state PARITY, giving frame length width_p+1.
REQ-028 SHALL, when PISO_TX_PARITY_EN is undefined, omit state PARITY; the frame length is width_p and the final data bit carries last_o.
REQ-029 SHALL apply the REQ-015/018/019 stall and back-to-back rules identically to the parity bit.

Verification
REQ-030 SHALL verify the basic frame: width_p=5, data_i=5'b10110 accepted, serial_ready_i=1 -> serial_o=1,0,1,1,0 on the next 5 cycles, last_o on the 5th only, then IDLE with ready_o=1.
REQ-031 SHALL verify back-to-back frames: 5'b10110 then 5'b01001 held valid -> 10 consecutive valid bits 1,0,1,1,0,0,1,0,0,1 with no gap; ready_o high exactly on the two final-bit cycles after the first.
REQ-032 SHALL verify stall handling: serial_ready_i=0 for 3 cycles after bit 2 of 5'b10110 -> serial_o held at 0 with serial_valid_o=1; the sequence then completes unchanged.
REQ-033 SHALL verify reset mid-frame: reset_i pulsed after bit 3 -> serial_valid_o=0 immediately (asynchronously); after release ready_o=1 and no residual bits.
REQ-034 SHALL verify parity: with PISO_TX_PARITY_EN, 5'b10110 -> 1,0,1,1,0,1 (parity bit 1), last_o on the 6th bit; 5'b11000 -> parity bit 0.
REQ-035 SHALL verify loopback: serial_o/serial_valid_o drive a width_p=5 shift receiver's d_i/en_i -> receiver data_o=5'b10110 after 5 transfers.

Source files
------------

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
//  Module   : piso_tx
//  Purpose  : Parallel-in / serial-out transmitter with valid/ready on both
//             sides. Words are sent MSB-first. Back-to-back frames run with
//             no idle cycle between them because a new word can be accepted
//             in the same cycle that the final bit of the current frame
//             transfers.
//  Option   : define PISO_TX_PARITY_EN to append one even-parity bit
//             (state PARITY) after the data bits. The frame then becomes
//             width_p+1 bits long.
//  Revision : 1.0  initial release
// ============================================================================
module piso_tx #(
    parameter int width_p = 5
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               serial_o,
    output logic               serial_valid_o,
    input  logic               serial_ready_i,
    output logic               last_o
);

    // Counter only needs to reach width_p-1 (width_p >= 2 keeps this >= 1 bit)
    localparam int                       c_cnt_w = $clog2(width_p);
    localparam logic [c_cnt_w-1:0]       c_last  = c_cnt_w'(width_p - 1);
`ifndef PISO_TX_PARITY_EN
    localparam logic [c_cnt_w-1:0]       c_pre_last = c_cnt_w'(width_p - 2);
`endif

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;
`endif

    state_t               r_state;
    logic [width_p-1:0]   r_shift;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_valid;   // registered serial_valid_o
    logic                 r_last;    // registered last_o
`ifdef PISO_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic                 w_accept;
    logic                 w_xfer;

    // Handshake decode. Reset gates ready_o so nothing is offered while held
    // in reset, even though the state registers already read IDLE.
    always_comb begin
        ready_o  = ~reset_i & (~r_valid | (r_last & serial_ready_i));
        w_accept = valid_i & ready_o;
        w_xfer   = r_valid & serial_ready_i;
    end

    // Output drive: every output is a register or a gated register bit
    always_comb begin
        serial_valid_o = r_valid;
        last_o         = r_last;
`ifdef PISO_TX_PARITY_EN
        serial_o = r_valid & ((r_state == PARITY) ? r_parity : r_shift[width_p-1]);
`else
        serial_o = r_valid & r_shift[width_p-1];
`endif
    end

    // Frame sequencer: acceptance has priority (it can only coincide with the
    // final-bit transfer or IDLE); otherwise advance on each bit transfer.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else if (w_accept) begin
            r_state  <= SEND;
            r_shift  <= data_i;
            r_cnt    <= '0;
            r_valid  <= 1'b1;
            r_last   <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            r_parity <= ^data_i;
`endif
        end else if (w_xfer) begin
            case (r_state)
                SEND: begin
                    r_shift <= {r_shift[width_p-2:0], 1'b0};
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last) begin
`ifdef PISO_TX_PARITY_EN
                        // Data done, parity bit is the final bit of the frame
                        r_state <= PARITY;
                        r_last  <= 1'b1;
`else
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
`endif
                    end else begin
`ifndef PISO_TX_PARITY_EN
                        r_last  <= (r_cnt == c_pre_last);
`endif
                    end
                end
`ifdef PISO_TX_PARITY_EN
                PARITY: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piso_tx
//  Purpose  : Directed self-checking bench for piso_tx (width_p = 5):
//             reset, basic frame, back-to-back, stalls, reset mid-frame,
//             parity (when PISO_TX_PARITY_EN is defined) and loopback.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_piso_tx;

    localparam int W = 5;
`ifdef PISO_TX_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk;
    logic         reset;
    logic         valid;
    logic [W-1:0] data;
    logic         ready;
    logic         serial;
    logic         serial_valid;
    logic         serial_ready;
    logic         last;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Loopback receiver: shift into LSB on each transfer, first 5 only
    logic         rx_clr;
    logic [W-1:0] rx_data;
    int           rx_cnt;

    piso_tx #(.width_p(W)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .valid_i        (valid),
        .data_i         (data),
        .ready_o        (ready),
        .serial_o       (serial),
        .serial_valid_o (serial_valid),
        .serial_ready_i (serial_ready),
        .last_o         (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_clr) begin
            rx_data <= '0;
            rx_cnt  <= 0;
        end else if (serial_valid && serial_ready && rx_cnt < W) begin
            rx_data <= {rx_data[W-2:0], serial};
            rx_cnt  <= rx_cnt + 1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [W-1:0] d, input int k);
        if (k < W) return d[W-1-k];
        return ^d;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_sv"},    serial_valid, 0);
        check({tag, "_ser"},   serial,       0);
        check({tag, "_last"},  last,         0);
        check({tag, "_ready"}, ready,        1);
    endtask

    // One frame, optional 3-cycle stall before bit index stall_at and a
    // one-cycle stall on the final bit.
    task automatic run_frame(input logic [W-1:0] d, input int stall_at, input bit stall_last);
        valid = 1'b1; data = d; serial_ready = 1'b1;
        #1 check("accept_ready", ready, 1);
        cyc;
        valid = 1'b0; data = '0;
        for (int k = 0; k < FL; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < 3; s++) begin
                    serial_ready = 1'b0;
                    #1;
                    check("stall_sv",    serial_valid, 1);
                    check("stall_ser",   serial,       exp_bit(d, k));
                    check("stall_ready", ready,        0);
                    cyc;
                end
            end
            if (stall_last && k == FL - 1) begin
                serial_ready = 1'b0;
                #1;
                check("stall_last_last",  last,  1);
                check("stall_last_ready", ready, 0);
                check("stall_last_ser",   serial, exp_bit(d, k));
                cyc;
            end
            serial_ready = 1'b1;
            #1;
            check("bit_sv",    serial_valid, 1);
            check("bit_ser",   serial,       exp_bit(d, k));
            check("bit_last",  last,         (k == FL - 1) ? 1 : 0);
            check("bit_ready", ready,        (k == FL - 1) ? 1 : 0);
            cyc;
        end
        #1 check_idle("after_frame");
    endtask

    task automatic run_b2b(input logic [W-1:0] d0, input logic [W-1:0] d1);
        valid = 1'b1; data = d0; serial_ready = 1'b1;
        #1 check("b2b_accept", ready, 1);
        cyc;
        data = d1;
        for (int k = 0; k < 2 * FL; k++) begin
            if (k == FL) valid = 1'b0;
            #1;
            check("b2b_sv",    serial_valid, 1);
            check("b2b_ser",   serial,       exp_bit((k < FL) ? d0 : d1, k % FL));
            check("b2b_last",  last,         (k % FL == FL - 1) ? 1 : 0);
            check("b2b_ready", ready,        (k % FL == FL - 1) ? 1 : 0);
            cyc;
        end
        #1 check_idle("after_b2b");
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; data = '0; serial_ready = 1'b1; rx_clr = 1'b1;

        // Reset held: all outputs low, ready included
        #2;
        check("rst_ready", ready,        0);
        check("rst_sv",    serial_valid, 0);
        check("rst_ser",   serial,       0);
        check("rst_last",  last,         0);
        cyc;
        reset = 1'b0;
        #1 check_idle("post_reset");
        cyc;

        // Basic frame and a second pattern (parity 0 when enabled)
        run_frame(5'b10110, -1, 1'b0);
        run_frame(5'b11000, -1, 1'b0);

        // Back-to-back frames with valid held
        run_b2b(5'b10110, 5'b01001);

        // Stall after bit 2 (shows index 1, value 0) plus a final-bit stall
        run_frame(5'b10110, 1, 1'b1);

        // Reset mid-frame after three bits
        valid = 1'b1; data = 5'b10110; serial_ready = 1'b1;
        #1;
        cyc;
        valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check("pre_rst_ser", serial, exp_bit(5'b10110, k));
            cyc;
        end
        #1 check("pre_rst_sv", serial_valid, 1);
        reset = 1'b1;
        #1;
        check("async_rst_sv",    serial_valid, 0);
        check("async_rst_ser",   serial,       0);
        check("async_rst_last",  last,         0);
        check("async_rst_ready", ready,        0);
        cyc;
        check("held_rst_sv", serial_valid, 0);
        reset = 1'b0;
        #1 check_idle("rst_release");
        cyc;
        #1 check("no_residual_sv", serial_valid, 0);
        cyc;

        // Loopback into a 5-bit receiver
        rx_clr = 1'b1;
        cyc;
        rx_clr = 1'b0;
        run_frame(5'b10110, -1, 1'b0);
        check("loop_cnt",  rx_cnt,  W);
        check("loop_data", rx_data, 5'b10110);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
